// File: rtl/fir_axil_regs_if.sv
// AXI4-Lite bus bundle for the FIR IP's S00_AXI register port.
// The system AXI master drives the master modport; the register block is the slave.
interface fir_axil_regs_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]              AWPROT;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [2:0]              ARPROT;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWPROT, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/fir_axil_regs.sv
// AXI4-Lite register file for the FIR datapath: NUM_REGS words with byte strobes,
// independent AW/W holding registers, and a one-cycle write pulse per register.
module fir_axil_regs #(
    parameter int NUM_REGS   = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    fir_axil_regs_if.slave               s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] REG_Q,
    output logic [NUM_REGS-1:0]          REG_WR
);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int SEL_W  = ADDR_WIDTH - 2;
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Write-side holding registers and response state
    logic                  aw_full;
    logic                  w_full;
    logic [SEL_W-1:0]      aw_idx_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;
    logic                  b_valid;
    resp_e                 b_resp;
    logic [NUM_REGS-1:0]   reg_wr;

    // Read-side response state
    logic                  r_valid;
    resp_e                 r_resp;
    logic [DATA_WIDTH-1:0] r_data;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  commit;
    logic [SEL_W-1:0]      ar_idx;
    logic [IDX_W-1:0]      aw_sel;
    logic [IDX_W-1:0]      ar_sel;

    function automatic logic in_range(input logic [SEL_W-1:0] idx);
        return 32'(idx) < 32'(NUM_REGS);
    endfunction

    // Readies depend only on local state and reset, never on the VALID inputs.
    assign s_axi.AWREADY = !aw_full && !ARESET;
    assign s_axi.WREADY  = !w_full  && !ARESET;
    assign s_axi.ARREADY = !r_valid && !ARESET;
    assign s_axi.BVALID  = b_valid;
    assign s_axi.BRESP   = b_resp;
    assign s_axi.RVALID  = r_valid;
    assign s_axi.RRESP   = r_resp;
    assign s_axi.RDATA   = r_data;
    assign REG_WR        = reg_wr;

    assign aw_hs  = s_axi.AWVALID && s_axi.AWREADY;
    assign w_hs   = s_axi.WVALID  && s_axi.WREADY;
    assign ar_hs  = s_axi.ARVALID && s_axi.ARREADY;
    assign commit = aw_full && w_full && !b_valid;
    assign ar_idx = s_axi.ARADDR[ADDR_WIDTH-1:2];
    assign aw_sel = aw_idx_q[IDX_W-1:0];
    assign ar_sel = ar_idx[IDX_W-1:0];

    logic unused_ok;
    assign unused_ok = ^{s_axi.AWPROT, s_axi.ARPROT, s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};

    always_ff @(posedge ACLK) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (ARESET) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            b_valid  <= 1'b0;
            b_resp   <= RESP_OKAY;
            reg_wr   <= '0;
            // NOTE: the register file is a handful of flops, so it is reset like any other state.
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else begin
            reg_wr <= '0;

            if (aw_hs) begin
                aw_full  <= 1'b1;
                aw_idx_q <= s_axi.AWADDR[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= s_axi.WDATA;
                w_strb_q <= s_axi.WSTRB;
            end

            // Commit waits for the previous response to drain, so BRESP never changes under BVALID.
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                b_valid <= 1'b1;
                if (in_range(aw_idx_q)) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_strb_q[b]) begin
                            regs[aw_sel][8*b +: 8] <= w_data_q[8*b +: 8];
                        end
                    end
                    reg_wr[aw_sel] <= 1'b1;
                    b_resp         <= RESP_OKAY;
                end else begin
                    b_resp <= RESP_SLVERR;
                end
            end else if (b_valid && s_axi.BREADY) begin
                b_valid <= 1'b0;
            end
        end
    end

    // A read coinciding with a commit samples regs before the NBA update: pre-commit value.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_valid <= 1'b0;
            r_resp  <= RESP_OKAY;
            r_data  <= '0;
        end else if (ar_hs) begin
            r_valid <= 1'b1;
            if (in_range(ar_idx)) begin
                r_data <= regs[ar_sel];
                r_resp <= RESP_OKAY;
            end else begin
                r_data <= '0;
                r_resp <= RESP_SLVERR;
            end
        end else if (r_valid && s_axi.RREADY) begin
            r_valid <= 1'b0;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path through this block can infer a latch.
        REG_Q = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            REG_Q[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
        end
    end
endmodule

// File: tb/tb_fir_axil_regs.sv
// Self-checking bench for fir_axil_regs: a transaction-level model (queues + memory array)
// is compared with the DUT every cycle, alongside directed scenarios with literal expectations.
module tb_fir_axil_regs;
    localparam int NUM_REGS   = 4;
    localparam int ADDR_WIDTH = 5;
    localparam int LIMIT      = 200;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } wbeat_t;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b1;
    logic [NUM_REGS*32-1:0] REG_Q;
    logic [NUM_REGS-1:0]    REG_WR;

    fir_axil_regs_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(32)) s ();

    fir_axil_regs #(
        .NUM_REGS  (NUM_REGS),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(32)
    ) dut (
        .ACLK  (ACLK),
        .ARESET(ARESET),
        .s_axi (s),
        .REG_Q (REG_Q),
        .REG_WR(REG_WR)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;
    int bready_mode = 1;  // 0: hold low, 1: hold high, 2: random
    int rready_mode = 1;
    logic [NUM_REGS-1:0] wr_log [$];
    logic [31:0] rd_d;
    logic [1:0]  rd_r;
    logic [1:0]  b_r;
    int mark;

    // Reference model: what the slave has accepted and what it must present.
    logic [31:0]           mem [NUM_REGS];
    logic [ADDR_WIDTH-1:0] aw_q [$];
    wbeat_t                w_q  [$];
    bit                    b_exp, r_exp;
    logic [1:0]            b_resp_exp, r_resp_exp;
    logic [31:0]           r_data_exp;
    logic [NUM_REGS-1:0]   wr_exp;

    initial forever #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: no handshake within %0d cycles at t=%0t", name, LIMIT, $time);
    endtask

    task automatic model_step();
        int idx;
        bit take_aw, take_w, take_ar, commit;
        logic [31:0] mask;
        logic [ADDR_WIDTH-1:0] a;
        wbeat_t w;
        if (ARESET) begin
            aw_q.delete();
            w_q.delete();
            b_exp = 0; r_exp = 0; wr_exp = '0;
            b_resp_exp = 2'b00; r_resp_exp = 2'b00; r_data_exp = '0;
            foreach (mem[k]) mem[k] = '0;
            return;
        end
        take_aw = s.AWVALID && aw_q.size() == 0;
        take_w  = s.WVALID && w_q.size() == 0;
        take_ar = s.ARVALID && !r_exp;
        commit  = aw_q.size() != 0 && w_q.size() != 0 && !b_exp;
        if (take_ar) begin
            idx = int'(s.ARADDR >> 2);
            r_exp = 1;
            r_data_exp = (idx < NUM_REGS) ? mem[idx] : 32'h0;
            r_resp_exp = (idx < NUM_REGS) ? 2'b00 : 2'b10;
        end else if (r_exp && s.RREADY) begin
            r_exp = 0;
        end
        wr_exp = '0;
        if (commit) begin
            a = aw_q.pop_front();
            w = w_q.pop_front();
            idx = int'(a >> 2);
            b_exp = 1;
            if (idx < NUM_REGS) begin
                mask = '0;
                for (int b = 0; b < 4; b++) if (w.strb[b]) mask |= 32'hFF << (8 * b);
                mem[idx] = (mem[idx] & ~mask) | (w.data & mask);
                wr_exp[idx] = 1'b1;
                b_resp_exp = 2'b00;
            end else begin
                b_resp_exp = 2'b10;
            end
        end else if (b_exp && s.BREADY) begin
            b_exp = 0;
        end
        if (take_aw) aw_q.push_back(s.AWADDR);
        if (take_w)  w_q.push_back({s.WDATA, s.WSTRB});
    endtask

    task automatic compare_step();
        logic [127:0] q_exp;
        foreach (mem[k]) q_exp[k*32 +: 32] = mem[k];
        check("awready", s.AWREADY, !ARESET && aw_q.size() == 0);
        check("wready", s.WREADY, !ARESET && w_q.size() == 0);
        check("arready", s.ARREADY, !ARESET && !r_exp);
        check("bvalid", s.BVALID, b_exp);
        if (b_exp) check("bresp", s.BRESP, b_resp_exp);
        check("rvalid", s.RVALID, r_exp);
        if (r_exp) begin
            check("rdata", s.RDATA, r_data_exp);
            check("rresp", s.RRESP, r_resp_exp);
        end
        check("reg_wr", REG_WR, wr_exp);
        check("reg_q", REG_Q, q_exp);
    endtask

    initial forever begin
        @(posedge ACLK);
        model_step();
    end

    initial forever begin
        @(negedge ACLK);
        if (chk_on) begin
            compare_step();
            if (REG_WR != '0) wr_log.push_back(REG_WR);
        end
    end

    // Sole driver of the response-ready inputs.
    initial forever begin
        @(posedge ACLK);
        #2;
        s.BREADY = (bready_mode == 2) ? 1'($urandom_range(0, 1)) : (bready_mode == 1);
        s.RREADY = (rready_mode == 2) ? 1'($urandom_range(0, 1)) : (rready_mode == 1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_WIDTH-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int n = 0;
        s.AWADDR = addr;
        s.AWPROT = 3'($urandom_range(0, 7));
        s.WDATA  = data;
        s.WSTRB  = strb;
        while (!(aw_done && w_done)) begin
            s.AWVALID = !aw_done && n >= aw_dly;
            s.WVALID  = !w_done && n >= w_dly;
            @(negedge ACLK);
            aw_hs = s.AWVALID && s.AWREADY;
            w_hs  = s.WVALID && s.WREADY;
            tick();
            aw_done |= aw_hs;
            w_done  |= w_hs;
            n++;
            if (n > LIMIT) begin
                timeout("write handshake");
                break;
            end
        end
        s.AWVALID = 1'b0;
        s.WVALID  = 1'b0;
    endtask

    task automatic aw_only(input logic [ADDR_WIDTH-1:0] addr);
        bit hs = 0;
        int n = 0;
        s.AWADDR  = addr;
        s.AWVALID = 1'b1;
        while (!hs) begin
            @(negedge ACLK);
            hs = s.AWREADY;
            tick();
            if (++n > LIMIT) begin
                timeout("aw handshake");
                break;
            end
        end
        s.AWVALID = 1'b0;
    endtask

    task automatic ar_only(input logic [ADDR_WIDTH-1:0] addr);
        bit hs = 0;
        int n = 0;
        s.ARADDR  = addr;
        s.ARPROT  = 3'($urandom_range(0, 7));
        s.ARVALID = 1'b1;
        while (!hs) begin
            @(negedge ACLK);
            hs = s.ARREADY;
            tick();
            if (++n > LIMIT) begin
                timeout("ar handshake");
                break;
            end
        end
        s.ARVALID = 1'b0;
    endtask

    task automatic r_wait(output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        data = 'x;
        resp = 'x;
        forever begin
            @(negedge ACLK);
            if (s.RVALID && s.RREADY) begin
                data = s.RDATA;
                resp = s.RRESP;
                tick();
                break;
            end
            tick();
            if (++n > LIMIT) begin
                timeout("r handshake");
                break;
            end
        end
    endtask

    task automatic do_read(input logic [ADDR_WIDTH-1:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
        ar_only(addr);
        r_wait(data, resp);
    endtask

    task automatic b_wait(output logic [1:0] resp);
        int n = 0;
        resp = 'x;
        forever begin
            @(negedge ACLK);
            if (s.BVALID && s.BREADY) begin
                resp = s.BRESP;
                tick();
                break;
            end
            tick();
            if (++n > LIMIT) begin
                timeout("b handshake");
                break;
            end
        end
    endtask

    initial begin
        s.AWADDR = '0; s.AWPROT = '0; s.AWVALID = 1'b0;
        s.WDATA = '0; s.WSTRB = '0; s.WVALID = 1'b0;
        s.ARADDR = '0; s.ARPROT = '0; s.ARVALID = 1'b0;

        // Reset state
        repeat (2) @(posedge ACLK);
        #1;
        chk_on = 1'b1;
        @(negedge ACLK);
        check("rst awready", s.AWREADY, 0);
        check("rst bvalid", s.BVALID, 0);
        check("rst rdata", s.RDATA, 0);
        check("rst reg_q", REG_Q, 0);
        tick();
        ARESET = 1'b0;

        // Sequential write then readback
        mark = wr_log.size();
        for (int i = 0; i < 4; i++) do_write(5'(i * 4), 32'(i + 1), 4'hF, 0, 0);
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            do_read(5'(i * 4), rd_d, rd_r);
            check($sformatf("seq rdata %0d", i), rd_d, 32'(i + 1));
            check($sformatf("seq rresp %0d", i), rd_r, 2'b00);
        end
        check("seq pulse count", wr_log.size() - mark, 4);
        for (int i = 0; i < 4; i++) check($sformatf("seq pulse %0d", i), wr_log[mark + i], 4'b0001 << i);

        // Channel skew in both directions
        mark = wr_log.size();
        do_write(5'h04, 32'hA5A5_0001, 4'hF, 0, 3);
        do_write(5'h08, 32'h5A5A_0002, 4'hF, 3, 0);
        repeat (4) tick();
        check("skew pulse count", wr_log.size() - mark, 2);
        do_read(5'h04, rd_d, rd_r);
        check("skew reg1", rd_d, 32'hA5A5_0001);
        do_read(5'h08, rd_d, rd_r);
        check("skew reg2", rd_d, 32'h5A5A_0002);

        // Write-response backpressure with a second write queued behind it
        bready_mode = 0;
        do_write(5'h04, 32'h0000_0055, 4'hF, 0, 0);
        do_write(5'h08, 32'h0000_0066, 4'hF, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("bp bvalid held", s.BVALID, 1);
            check("bp bresp held", s.BRESP, 2'b00);
            check("bp reg2 not yet", REG_Q[64 +: 32], 32'h5A5A_0002);
            tick();
        end
        bready_mode = 1;
        b_wait(b_r);
        b_wait(b_r);
        check("bp reg1", REG_Q[32 +: 32], 32'h0000_0055);
        check("bp reg2", REG_Q[64 +: 32], 32'h0000_0066);

        // Read-response backpressure
        rready_mode = 0;
        ar_only(5'h04);
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            check("rbp rvalid", s.RVALID, 1);
            check("rbp arready", s.ARREADY, 0);
            check("rbp rdata", s.RDATA, 32'h0000_0055);
            tick();
        end
        rready_mode = 1;
        r_wait(rd_d, rd_r);

        // Byte strobes
        do_write(5'h00, 32'h1122_3344, 4'hF, 0, 0);
        do_write(5'h00, 32'hAABB_CCDD, 4'b0101, 0, 0);
        repeat (3) tick();
        do_read(5'h00, rd_d, rd_r);
        check("strobe readback", rd_d, 32'h11BB_33DD);

        // Out-of-range address
        repeat (2) tick();
        mark = wr_log.size();
        do_write(5'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
        b_wait(b_r);
        check("oor bresp", b_r, 2'b10);
        check("oor no pulse", wr_log.size() - mark, 0);
        check("oor regs", REG_Q, {32'h4, 32'h66, 32'h55, 32'h11BB_33DD});
        do_read(5'h10, rd_d, rd_r);
        check("oor rdata", rd_d, 0);
        check("oor rresp", rd_r, 2'b10);

        // Reset with a lone AW held
        aw_only(5'h0C);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        @(negedge ACLK);
        check("mid rst awready", s.AWREADY, 1);
        check("mid rst reg_q", REG_Q, 0);
        check("mid rst rdata", s.RDATA, 0);
        check("mid rst rresp", s.RRESP, 0);
        check("mid rst bresp", s.BRESP, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            check("mid rst no bvalid", s.BVALID, 0);
            tick();
        end
        do_write(5'h08, 32'h0000_0077, 4'hF, 0, 0);
        b_wait(b_r);
        check("post rst bresp", b_r, 2'b00);
        do_read(5'h08, rd_d, rd_r);
        check("post rst readback", rd_d, 32'h77);
        check("post rst reg_q", REG_Q, 128'h77 << 64);

        // Randomized concurrent traffic against the model
        bready_mode = 2;
        rready_mode = 2;
        for (int i = 0; i < 150; i++) begin
            fork
                do_write(5'($urandom_range(0, 31)), $urandom(), 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3));
                do_read(5'($urandom_range(0, 31)), rd_d, rd_r);
            join
        end
        bready_mode = 1;
        rready_mode = 1;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
